// File: rtl/collatz_pkg.sv
// collatz_pkg: shared definitions for the Collatz step-count engine and the
// display path that consumes its step count.
//   state_e    : engine FSM states (IDLE, RUN, DONE)
//   DEF_*      : default seed / trajectory / count widths and saturation value
//   COUNT_MAX  : four-digit display limit, shared with the BCD converter side
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_W     = 16;
    localparam int DEF_IW    = 32;
    localparam int DEF_CW    = 14;
    localparam int COUNT_MAX = 9999;
    localparam int DEF_CMAX  = COUNT_MAX;

endpackage

// File: rtl/collatz_if.sv
// collatz_if: request/result bundle between a controller and collatz_engine.
// Handshake: the controller pulses start with seed valid in that cycle; the
// request is taken only when the engine is not busy. busy is high while
// iterating, done rises when the result is final and stays high until the
// next accepted start. steps/sat/err are valid whenever done is high.
//   master : drives start, seed; observes busy, done, steps, sat, err
//   slave  : the engine side
import collatz_pkg::*;

interface collatz_if #(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) ();
    logic          start;
    logic [W-1:0]  seed;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps;
    logic          sat;
    logic          err;

    modport master (output start, seed, input busy, done, steps, sat, err);
    modport slave  (input start, seed, output busy, done, steps, sat, err);
endinterface

// File: rtl/collatz_step.sv
// collatz_step: one combinational Collatz step on an IW-bit value.
//   cur_i     : current trajectory value
//   next_o    : cur/2 if even, 3*cur+1 (low IW bits) if odd
//   is_one_o  : cur == 1
//   is_zero_o : cur == 0
//   ovf_o     : cur odd and 3*cur+1 does not fit in IW bits
import collatz_pkg::*;

module collatz_step #(
    parameter int IW = DEF_IW
) (
    input  logic [IW-1:0] cur_i,
    output logic [IW-1:0] next_o,
    output logic          is_one_o,
    output logic          is_zero_o,
    output logic          ovf_o
);
    // 3n+1 needs two extra bits to be exact for any IW-bit n.
    logic [IW+1:0] wide;
    logic [IW+1:0] r;

    always_comb begin
        wide      = {2'b00, cur_i};
        r         = (wide << 1) + wide + {{(IW+1){1'b0}}, 1'b1};
        is_one_o  = (cur_i == {{(IW-1){1'b0}}, 1'b1});
        is_zero_o = (cur_i == '0);
        ovf_o     = cur_i[0] & (r[IW+1:IW] != 2'b00);
        next_o    = cur_i[0] ? r[IW-1:0] : (cur_i >> 1);
    end
endmodule

// File: rtl/collatz_engine.sv
// collatz_engine: sequential Collatz iterator feeding the BCD display path.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : collatz_if slave (start/seed in; busy/done/steps/sat/err out)
//   state_o : current FSM state, for observation
// One step is applied per RUN cycle. busy/done are registered from the
// state register, so they trail the state by one cycle; this places done at
// T+k+2 for an accept at edge T and a seed needing k steps.
import collatz_pkg::*;

module collatz_engine #(
    parameter int W    = DEF_W,
    parameter int IW   = DEF_IW,
    parameter int CW   = DEF_CW,
    parameter int CMAX = DEF_CMAX
) (
    input  logic       clk,
    input  logic       rst_n,
    collatz_if.slave   bus,
    output state_e     state_o
);
    state_e        state_q, state_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [CW-1:0] steps_q, steps_d;
    logic          sat_q, sat_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [IW-1:0] nxt;
    logic          is_one, is_zero, ovf;

    collatz_step #(.IW(IW)) u_step (
        .cur_i     (cur_q),
        .next_o    (nxt),
        .is_one_o  (is_one),
        .is_zero_o (is_zero),
        .ovf_o     (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            steps_q <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        steps_d = steps_q;
        sat_d   = sat_q;
        err_d   = err_q;
        busy_d  = (state_q == RUN);
        done_d  = (state_q == DONE);
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    cur_d   = IW'(bus.seed);
                    steps_d = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (is_zero) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (is_one) begin
                    state_d = DONE;
                end else if (ovf) begin
                    // Failing step is not applied: cur and steps stay put.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cur_d = nxt;
                    // Saturated count holds; iteration still runs to 1.
                    if (steps_q == CW'(CMAX)) sat_d = 1'b1;
                    else                      steps_d = steps_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.steps = steps_q;
    assign bus.sat   = sat_q;
    assign bus.err   = err_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_collatz_engine.sv
// tb_collatz_engine: three engines (default, IW=13 with W=13, CMAX=100) share
// one stimulus stream; a reference model predicts steps/sat/err/latency.
import collatz_pkg::*;

module tb_collatz_engine;
  typedef struct {
    int          done_cyc;
    int          busy_cyc;
    logic [13:0] steps;
    logic        sat;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  exp_t exp_q[3][$];
  logic prev_done[3];
  int   busy_cnt[3];

  state_e st0, st1, st2;

  collatz_if #(.W(16), .CW(14)) if0 ();
  collatz_if #(.W(13), .CW(14)) if1 ();
  collatz_if #(.W(16), .CW(14)) if2 ();

  assign if0.start = start;
  assign if1.start = start;
  assign if2.start = start;
  assign if0.seed  = seed;
  assign if1.seed  = seed[12:0];
  assign if2.seed  = seed;

  collatz_engine #(.W(16), .IW(32), .CW(14), .CMAX(9999)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_o(st0));
  collatz_engine #(.W(13), .IW(13), .CW(14), .CMAX(9999)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_o(st1));
  collatz_engine #(.W(16), .IW(32), .CW(14), .CMAX(100))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_o(st2));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: walk the trajectory with plain integer arithmetic
  function automatic exp_t model(input longint unsigned s, input int iw, input int cmax, input int t);
    exp_t e;
    longint unsigned n = s;
    longint unsigned r;
    int applied = 0;
    e.err = 1'b0;
    if (n == 0) e.err = 1'b1;
    else begin
      while (n != 1 && applied < 100000) begin
        if (n % 2 == 0) n = n / 2;
        else begin
          r = 3 * n + 1;
          if (r >= (64'd1 << iw)) begin
            e.err = 1'b1;
            break;
          end
          n = r;
        end
        applied++;
      end
    end
    e.steps    = 14'((applied > cmax) ? cmax : applied);
    e.sat      = (applied > cmax);
    e.done_cyc = t + applied + 2;
    e.busy_cyc = applied + 1;
    return e;
  endfunction

  // scoreboard monitor
  task automatic mon(input int i, input logic d, input logic b, input logic [13:0] st,
                     input logic sa, input logic er);
    exp_t e;
    if (b) busy_cnt[i]++;
    if (d && b) chk($sformatf("busy_and_done[%0d]", i), 1, 0);
    if (d && !prev_done[i]) begin
      if (exp_q[i].size() == 0) chk($sformatf("unexpected_done[%0d]", i), 1, 0);
      else begin
        e = exp_q[i].pop_front();
        chk($sformatf("done_cycle[%0d]", i), cyc, e.done_cyc);
        chk($sformatf("steps[%0d]", i), st, e.steps);
        chk($sformatf("sat[%0d]", i), sa, e.sat);
        chk($sformatf("err[%0d]", i), er, e.err);
        chk($sformatf("busy_cycles[%0d]", i), busy_cnt[i], e.busy_cyc);
      end
      busy_cnt[i] = 0;
    end
    prev_done[i] = d;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        prev_done[i] = 1'b0;
        busy_cnt[i]  = 0;
      end
    end else begin
      mon(0, if0.done, if0.busy, if0.steps, if0.sat, if0.err);
      mon(1, if1.done, if1.busy, if1.steps, if1.sat, if1.err);
      mon(2, if2.done, if2.busy, if2.steps, if2.sat, if2.err);
    end
  end

  // driver tasks
  task automatic wait_all_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if0.done && if1.done && if2.done) && n < 3000);
    chk("all_done_in_time", (if0.done && if1.done && if2.done), 1);
  endtask

  task automatic issue(input logic [15:0] s);
    int t;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    t = cyc + 1;
    exp_q[0].push_back(model(s, 32, 9999, t));
    exp_q[1].push_back(model(s & 16'h1fff, 13, 9999, t));
    exp_q[2].push_back(model(s, 32, 100, t));
    @(negedge clk);
    start = 1'b0;
    seed  = 16'($urandom_range(0, 65535));
    chk("done_low_after_accept", if0.done, 0);
  endtask

  task automatic run_seed(input logic [15:0] s, input bit glitch);
    issue(s);
    if (glitch) begin
      repeat (2) @(negedge clk);
      start = 1'b1; seed = 16'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      start = 1'b1; seed = 16'd1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_all_done();
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_0"}, {if0.busy, if0.done, if0.sat, if0.err, if0.steps}, 0);
    chk({name, "_1"}, {if1.busy, if1.done, if1.sat, if1.err, if1.steps}, 0);
    chk({name, "_2"}, {if2.busy, if2.done, if2.sat, if2.err, if2.steps}, 0);
    chk({name, "_state"}, st0, IDLE);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outs("reset_outputs");
    #2 rst_n = 1'b1;

    run_seed(16'd1, 1'b0);
    run_seed(16'd6, 1'b0);
    run_seed(16'd27, 1'b0);
    run_seed(16'd6, 1'b0);   // restart from DONE
    run_seed(16'd0, 1'b0);
    run_seed(16'd27, 1'b1);  // start pulses during RUN

    // asynchronous reset in the middle of a run
    issue(16'd27);
    repeat (48) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("mid_run_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_seed(16'd27, 1'b0);

    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 9) run_seed(16'd0, 1'b0);
      else             run_seed(16'($urandom_range(1, 65535)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
